rv_data_in_fifo_bfm: RTL and testbench
======================================

// Module: rv_data_in_fifo_bfm
// PURPOSE
//  Sink-side ready/valid BFM for cocotb benches. Captures beats from a DUT source into an
//  internal FIFO of DEPTH entries. Drives data_ready from a selectable backpressure mode
//  (always, stall, pseudo-random, duty-cycle). The Python BFM drains beats through a
//  show-ahead pop port. This is the parametrised successor of the plain ready/valid input BFM.
// PARAMETERS
//  DATA_WIDTH   8        width of data / host_data
//  DEPTH        16       FIFO entries; power of 2, >=2
//  COUNT_WIDTH  32       width of beat_count (wraps)
//  LFSR_SEED    16'hACE1 LFSR reset value; must be non-zero
// PORTS
//  clock       in   1            sole clock, rising edge
//  reset       in   1            asynchronous, active-high
//  data        in   DATA_WIDTH   beat payload from DUT
//  data_valid  in   1            DUT offers beat
//  data_ready  out  1            BFM accepts beat
//  ready_mode  in   2            0 always, 1 stall, 2 random, 3 duty
//  ready_duty  in   4            mode 3: ready slots per 16-cycle window (0..15)
//  host_pop    in   1            remove head entry
//  host_valid  out  1            FIFO non-empty
//  host_data   out  DATA_WIDTH   head entry (show-ahead)
//  level       out  $clog2(DEPTH+1)  entries held, 0..DEPTH
//  beat_count  out  COUNT_WIDTH  total accepted beats, mod 2^COUNT_WIDTH
// BEHAVIOUR
//  - Reset (async assert, sync release): data_ready=0, host_valid=0, level=0, beat_count=0,
//    lfsr=LFSR_SEED, window counter=0, FIFO pointers=0. host_data is don't-care.
//    Reset mid-transfer discards all held beats; no beat is accepted in the reset cycle.
//  - data_ready = allow & (level != DEPTH). allow is a register updated every cycle:
//    mode0: 1; mode1: 0; mode2: lfsr[0]; mode3: (win_cnt < ready_duty).
//  - win_cnt is 4 bits, increments every cycle, wraps 15->0. ready_duty=0 means never ready.
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11. It shifts every cycle in all modes.
//  - A mode change takes effect on allow one cycle later; the full gating is immediate.
//  - Accept: data_valid & data_ready at posedge -> write data at wr_ptr and advance wr_ptr;
//    beat_count+1, which wraps silently.
//  - data_ready never depends on data_valid. No combinational in->out path except full gating.
//  - Pop: host_pop & host_valid at posedge -> advance rd_ptr. A pop while empty is ignored,
//    leaves state unchanged, and is not an error.
//  - host_data = mem[rd_ptr] whenever host_valid=1. Zero latency push->visible: a beat
//    accepted at edge N gives host_valid=1 after edge N.
//  - Simultaneous accept+pop: level unchanged, both pointers advance.
//  - Full (level==DEPTH): data_ready=0 that cycle even if a pop is in flight, so there is no
//    fall-through. Ready returns the cycle after level drops.
//  - Pointers are log2(DEPTH)+1 bits. Empty = pointers equal; full = MSB differs, rest equal.
//  - The source may hold data_valid indefinitely. Data presented while ready=0 is never captured.
// TESTING
//  1 Mode0, DEPTH=16, send 5 beats 0x01..0x05 back-to-back, no pops -> data_ready high
//    throughout, level=5, beat_count=5; 5 pops return 0x01..0x05 in order, host_valid drops
//    after the 5th pop.
//  2 Mode0, 20 beats, no pops -> ready falls after the 16th accept, level=16, beat_count=16.
//    One pop -> ready high the next cycle, 17th beat accepted, beat_count=17.
//  3 Mode1 with data_valid held at 0xAA for 50 cycles -> no accept, level=0. Switch to mode0
//    -> 0xAA accepted 1 cycle later.
//  4 Mode3, ready_duty=4, continuous valid, 64 cycles -> exactly 16 accepts, ready high in 4
//    consecutive cycles of each 16. ready_duty=0 -> 0 accepts.
//  5 Mode2, 1000 cycles, continuous valid with continuous pops -> the data_ready sequence
//    matches the Python LFSR model from seed 0xACE1, with accept ratio ~50%; the data
//    sequence is preserved.
//  6 Reset asserted mid-stream with level=7 -> level=0, beat_count=0, host_valid=0,
//    data_ready=0 immediately (async). Traffic resumes correctly after release.

Source files
------------

// File: rtl/rv_data_in_fifo_bfm.sv
// Sink-side ready/valid BFM: captures DUT beats into a show-ahead FIFO,
// with data_ready shaped by a selectable backpressure mode.
module rv_data_in_fifo_bfm #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        data,
  input  logic                         data_valid,
  output logic                         data_ready,
  input  logic [1:0]                   ready_mode,
  input  logic [3:0]                   ready_duty,
  input  logic                         host_pop,
  output logic                         host_valid,
  output logic [DATA_WIDTH-1:0]        host_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [COUNT_WIDTH-1:0]       beat_count
);

  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W   = ADDR_W + 1;
  localparam int unsigned LEVEL_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    MODE_ALWAYS = 2'd0,
    MODE_STALL  = 2'd1,
    MODE_RANDOM = 2'd2,
    MODE_DUTY   = 2'd3
  } mode_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  allow;
  logic [15:0]           lfsr;
  logic [3:0]            win_cnt;
  logic                  empty;
  logic                  full;
  logic                  accept;
  logic                  pop;
  logic                  lfsr_fb;
  logic                  allow_nxt;

  // Wrap-bit pointer compare distinguishes full from empty.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // Full gating is the only combinational term on ready; never depends on data_valid.
  assign data_ready = allow & ~full;
  assign accept     = data_valid & data_ready;
  assign pop        = host_pop & ~empty;

  assign host_valid = ~empty;
  assign host_data  = mem[rd_ptr[ADDR_W-1:0]];
  assign level      = LEVEL_W'(wr_ptr - rd_ptr);

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_comb begin
    allow_nxt = 1'b0;
    case (mode_e'(ready_mode))
      MODE_ALWAYS: allow_nxt = 1'b1;
      MODE_STALL:  allow_nxt = 1'b0;
      MODE_RANDOM: allow_nxt = lfsr[0];
      MODE_DUTY:   allow_nxt = (win_cnt < ready_duty);
      default:     allow_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      allow      <= 1'b0;
      lfsr       <= LFSR_SEED;
      win_cnt    <= '0;
      beat_count <= '0;
    end else begin
      allow   <= allow_nxt;
      lfsr    <= {lfsr_fb, lfsr[15:1]};
      win_cnt <= win_cnt + 4'(1);
      if (accept) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        beat_count <= beat_count + COUNT_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset; contents are only visible while host_valid is high.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wr_ptr[ADDR_W-1:0]] <= data;
    end
  end

endmodule

// File: tb/tb_rv_data_in_fifo_bfm.sv
// Bench for rv_data_in_fifo_bfm: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_rv_data_in_fifo_bfm;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          data_ready;
  logic [1:0]    ready_mode;
  logic [3:0]    ready_duty;
  logic          host_pop;
  logic          host_valid;
  logic [DW-1:0] host_data;
  logic [4:0]    level;
  logic [CW-1:0] beat_count;

  rv_data_in_fifo_bfm #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .COUNT_WIDTH(CW),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .ready_mode (ready_mode),
    .ready_duty (ready_duty),
    .host_pop   (host_pop),
    .host_valid (host_valid),
    .host_data  (host_data),
    .level      (level),
    .beat_count (beat_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  int unsigned   m_cnt;
  bit            m_allow;
  int unsigned   m_lfsr;
  int unsigned   m_win;

  // Observations taken at the negedge of the last cycle
  logic          obs_ready, obs_hv;
  logic [DW-1:0] obs_hd;
  logic [4:0]    obs_level;
  logic [CW-1:0] obs_cnt;
  bit            obs_acc;

  typedef struct {
    logic          valid;
    logic [DW-1:0] d;
    logic          pop;
    logic          e_ready;
    logic          e_hv;
    logic [DW-1:0] e_hd;
    int            e_level;
    int            e_cnt;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    mq.delete();
    m_cnt   = 0;
    m_allow = 1'b0;
    m_lfsr  = 32'hACE1;
    m_win   = 0;
  endfunction

  function automatic bit m_ready();
    return m_allow && (mq.size() != DEPTH);
  endfunction

  // One clock edge of the specified behaviour, applied to the current inputs.
  function automatic void m_step();
    bit          acc, pp;
    int unsigned bit0, fb;
    acc = data_valid && m_ready();
    pp  = host_pop && (mq.size() > 0);
    if (pp) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(data);
      m_cnt = m_cnt + 1;
    end
    bit0 = m_lfsr % 2;
    case (ready_mode)
      2'd0: m_allow = 1'b1;
      2'd1: m_allow = 1'b0;
      2'd2: m_allow = (bit0 == 1);
      default: m_allow = (m_win < ready_duty);
    endcase
    fb     = (m_lfsr ^ (m_lfsr / 4) ^ (m_lfsr / 8) ^ (m_lfsr / 32)) % 2;
    m_lfsr = (m_lfsr / 2) + fb * 32768;
    m_win  = (m_win + 1) % 16;
  endfunction

  task automatic cycle();
    @(negedge clock);
    chk("ready", 64'(data_ready), 64'(m_ready()));
    chk("host_valid", 64'(host_valid), 64'(mq.size() > 0));
    chk("level", 64'(level), 64'(mq.size()));
    chk("beat_count", 64'(beat_count), 64'(m_cnt));
    if (mq.size() > 0) chk("host_data", 64'(host_data), 64'(mq[0]));
    obs_ready = data_ready;
    obs_hv    = host_valid;
    obs_hd    = host_data;
    obs_level = level;
    obs_cnt   = beat_count;
    obs_acc   = data_valid && data_ready;
    m_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ready", 64'(data_ready), 64'd0);
    chk("rst_host_valid", 64'(host_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_beat_count", 64'(beat_count), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_reset();
  endtask

  task automatic set_in(input logic v, input logic [DW-1:0] d, input logic p);
    data_valid = v;
    data       = d;
    host_pop   = p;
  endtask

  initial begin
    int acc_n, rises;
    logic prev;

    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0};
    vecs[1]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0};
    vecs[2]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 1, 1};
    vecs[3]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 2, 2};
    vecs[4]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 3, 3};
    vecs[5]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h01, 4, 4};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 5, 5};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 4, 5};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 3, 5};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 2, 5};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 1, 5};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0, 5};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 5};

    reset = 1'b1;
    ready_mode = 2'd0;
    ready_duty = 4'd0;
    set_in(1'b0, '0, 1'b0);
    @(posedge clock);
    #1;
    do_reset();

    // Mode 0: five beats in, five pops out, trailing pop on empty ignored
    foreach (vecs[i]) begin
      set_in(vecs[i].valid, vecs[i].d, vecs[i].pop);
      cycle();
      chk($sformatf("vec%0d_ready", i), 64'(obs_ready), 64'(vecs[i].e_ready));
      chk($sformatf("vec%0d_hv", i), 64'(obs_hv), 64'(vecs[i].e_hv));
      chk($sformatf("vec%0d_level", i), 64'(obs_level), 64'(vecs[i].e_level));
      chk($sformatf("vec%0d_cnt", i), 64'(obs_cnt), 64'(vecs[i].e_cnt));
      if (vecs[i].e_hv) chk($sformatf("vec%0d_hd", i), 64'(obs_hd), 64'(vecs[i].e_hd));
    end

    // Fill to full; a pop in the full cycle must not let a beat fall through
    do_reset();
    ready_mode = 2'd0;
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, DW'(8'h10 + i), 1'b0);
      cycle();
    end
    chk("full_level", 64'(level), 64'd16);
    chk("full_ready", 64'(data_ready), 64'd0);
    chk("full_cnt", 64'(beat_count), 64'd16);
    set_in(1'b1, 8'h77, 1'b1);
    cycle();
    chk("full_pop_ready", 64'(obs_ready), 64'd0);
    set_in(1'b1, 8'h77, 1'b0);
    cycle();
    chk("after_pop_ready", 64'(obs_ready), 64'd1);
    chk("after_pop_cnt", 64'(beat_count), 64'd17);
    chk("after_pop_level", 64'(level), 64'd16);

    // Stall holds off a persistent offer; mode 0 takes it one cycle after switching
    do_reset();
    ready_mode = 2'd1;
    set_in(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 50; i++) cycle();
    chk("stall_level", 64'(level), 64'd0);
    chk("stall_cnt", 64'(beat_count), 64'd0);
    ready_mode = 2'd0;
    cycle();
    chk("switch_ready_lag", 64'(obs_ready), 64'd0);
    cycle();
    chk("switch_ready", 64'(obs_ready), 64'd1);
    chk("switch_level", 64'(level), 64'd1);
    chk("switch_data", 64'(host_data), 64'hAA);

    // Duty 4/16 with continuous valid and pops
    do_reset();
    ready_mode = 2'd3;
    ready_duty = 4'd4;
    set_in(1'b1, 8'h5A, 1'b1);
    cycle();
    prev = obs_ready;
    acc_n = 0;
    rises = 0;
    for (int i = 0; i < 64; i++) begin
      data = DW'($urandom);
      cycle();
      if (obs_acc) acc_n++;
      if (obs_ready && !prev) rises++;
      prev = obs_ready;
    end
    chk("duty4_accepts", 64'(acc_n), 64'd16);
    chk("duty4_windows", 64'(rises), 64'd4);
    ready_duty = 4'd0;
    cycle();
    acc_n = 0;
    for (int i = 0; i < 64; i++) begin
      cycle();
      if (obs_acc) acc_n++;
    end
    chk("duty0_accepts", 64'(acc_n), 64'd0);

    // Pseudo-random ready from the reset seed
    do_reset();
    ready_mode = 2'd2;
    acc_n = 0;
    for (int i = 0; i < 1000; i++) begin
      set_in(1'b1, DW'($urandom), 1'b1);
      cycle();
      if (obs_acc) acc_n++;
    end
    chk("random_ratio_ok", 64'((acc_n > 400) && (acc_n < 600)), 64'd1);

    // Async reset with seven beats held, then traffic resumes
    do_reset();
    ready_mode = 2'd0;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, DW'(i + 1), 1'b0);
      cycle();
    end
    chk("pre_reset_level", 64'(level), 64'd7);
    do_reset();
    for (int i = 0; i < 30; i++) begin
      set_in(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
      cycle();
    end

    // Randomized traffic over all modes
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        ready_mode = 2'($urandom);
        ready_duty = 4'($urandom);
      end
      set_in(($urandom_range(0, 9) < 7), DW'($urandom), ($urandom_range(0, 9) < 4));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
